multicycle_control: RTL

Main control state machine for the multicycle MIPS datapath. It sequences one shared ALU, one unified instruction/data memory port and the register file across fetch, decode, execute, memory and write-back cycles. It drives the 3-bit ALUOp consumed by the ALU control decoder, plus all datapath multiplexer selects and write strobes. It stretches memory states until the memory port signals ready.

---
 rtl/multicycle_control.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for a multicycle MIPS datapath. One shared ALU, one
// unified instruction/data memory port and the register file are sequenced
// through fetch, decode, execute, memory and write-back cycles. Memory states
// stretch until the memory port reports MemReady.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high; forces FETCH
//   Opcode    in   [5:0] instruction[31:26], stable from DECODE onward
//   Zero      in   ALU zero flag (branch compare)
//   MemReady  in   memory port completes the current access this cycle
//   PCEn      out  program counter load enable
//   IorD      out  memory address select (0 = PC, 1 = ALUOut)
//   MemRead   out  memory read strobe
//   MemWrite  out  memory write strobe
//   IRWrite   out  instruction register load
//   RegDst    out  write register select (0 = rt, 1 = rd)
//   MemtoReg  out  write data select (0 = ALUOut, 1 = MDR)
//   RegWrite  out  register file write
//   ALUSrcA   out  ALU A select (0 = PC, 1 = A)
//   ALUSrcB   out  [1:0] ALU B select (B, 4, ext imm, imm<<2)
//   ALUOp     out  [2:0] operation code for the ALU control decoder
//   PCSource  out  [1:0] PC source (ALU, ALUOut, jump target)
//   Illegal   out  sticky unsupported-opcode flag (set while in TRAP)
//   State     out  [3:0] current state for debug
// ---------------------------------------------------------------------------
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  // Opcode map
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  // ALUOp codes understood by the ALU control decoder
  localparam logic [2:0] ALU_AND   = 3'b001;
  localparam logic [2:0] ALU_MEMAD = 3'b010;
  localparam logic [2:0] ALU_LUI   = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_ADD   = 3'b110;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  // ALUSrcB selections
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  // PCSource selections
  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_BTGT = 2'b01;
  localparam logic [1:0] PCS_JTGT = 2'b10;

  // ALU operation for the immediate ALU instructions; only reached with a
  // legal I-type opcode, so the fallback add is never observed in practice.
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    logic [2:0] r;
    case (op)
      OP_ORI:  r = ALU_OR;
      OP_ANDI: r = ALU_AND;
      OP_LUI:  r = ALU_LUI;
      OP_ADDI: r = ALU_ADD;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  // Instruction class dispatch taken at the end of DECODE.
  function automatic state_t decode_target(input logic [5:0] op);
    state_t r;
    case (op)
      OP_LW, OP_SW:                     r = S_MEMADR;
      OP_R:                             r = S_REXEC;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: r = S_IEXEC;
      OP_BEQ:                           r = S_BRANCH;
      OP_J:                             r = S_JUMP;
      default:                          r = S_TRAP;
    endcase
    return r;
  endfunction

  state_t state_q;
  state_t state_d;

  // State register with asynchronous reset to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (MemReady) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: state_d = decode_target(Opcode);
      S_MEMADR: begin
        // Only LW and SW reach this state; the opcode picks the access type.
        if (Opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMRD: begin
        if (MemReady) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWB: state_d = S_FETCH;
      S_MEMWR: begin
        if (MemReady) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_REXEC:  state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode of the current state
  always_comb begin
    PCEn     = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_REG;
    ALUOp    = 3'b000;
    PCSource = PCS_ALU;
    Illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 is computed every FETCH cycle but only committed together
        // with the instruction once memory delivers it.
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        ALUOp    = ALU_ADD;
        PCSource = PCS_ALU;
        IRWrite  = MemReady;
        PCEn     = MemReady;
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        ALUSrcB = SRCB_BOFS;
        ALUOp   = ALU_ADD;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_MEMAD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REG;
        ALUOp   = ALU_RTYPE;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = imm_alu_op(Opcode);
      end
      S_IWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_REG;
        ALUOp    = ALU_SUB;
        PCSource = PCS_BTGT;
        PCEn     = Zero;
      end
      S_JUMP: begin
        PCSource = PCS_JTGT;
        PCEn     = 1'b1;
      end
      S_TRAP: begin
        // Stays here until reset, which keeps the flag sticky.
        Illegal = 1'b1;
      end
      default: begin
        // Unreachable encodings: everything stays deasserted.
        Illegal = 1'b0;
      end
    endcase

    // The state register is already FETCH during reset; additionally kill
    // every write-type strobe so nothing commits while reset is high.
    if (reset) begin
      PCEn     = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      Illegal  = 1'b0;
    end else begin
      Illegal  = Illegal;
    end
  end

  assign State = state_q;

endmodule
